// File: rtl/axi_pkg.sv
// AXI protocol constants shared across the hyperbus controller.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/hyperbus_pkg.sv
// Shared hyperbus types and helpers.
package hyperbus_pkg;

  typedef logic [15:0] hyper_word_t;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    SEND
  } rx_state_e;

  function automatic int unsigned words_per_beat(
    input int unsigned dw
  );
    return dw / 16;
  endfunction

endpackage

// File: rtl/hyper_rx_upsizer.sv
// Packs 16-bit PHY read words into AXI R beats,
// one burst at a time.
module hyper_rx_upsizer
  import hyperbus_pkg::*;
  import axi_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [$clog2(words_per_beat(AxiDataWidth))-1:0]
                                  cmd_offset_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [AxiIdWidth-1:0]   cmd_id_i,
  input  logic                    phy_valid_i,
  output logic                    phy_ready_o,
  input  hyper_word_t             phy_data_i,
  input  logic                    phy_err_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o
);

  localparam int unsigned WordsPerBeat =
    words_per_beat(AxiDataWidth);
  localparam int unsigned LaneW = $clog2(WordsPerBeat);

  typedef logic [WordsPerBeat-1:0][15:0] beat_t;

  rx_state_e             state_q, state_d;
  logic [AxiIdWidth-1:0] id_q, id_d;
  logic [7:0]            beats_q, beats_d;
  logic [LaneW-1:0]      lane_q, lane_d;
  beat_t                 asm_q, asm_d;
  beat_t                 data_q, data_d;
  logic                  err_q, err_d;
  resp_t                 resp_q, resp_d;
  logic                  last_q, last_d;
  logic                  err_n;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    beats_d     = beats_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    data_d      = data_q;
    err_d       = err_q;
    resp_d      = resp_q;
    last_d      = last_q;
    cmd_ready_o = 1'b0;
    phy_ready_o = 1'b0;
    r_valid_o   = 1'b0;
    err_n       = err_q | phy_err_i;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          id_d    = cmd_id_i;
          beats_d = cmd_len_i;
          lane_d  = cmd_offset_i;
          asm_d   = '0;
          err_d   = 1'b0;
          state_d = PACK;
        end
      end
      PACK: begin
        phy_ready_o = 1'b1;
        if (phy_valid_i) begin
          asm_d[lane_q] = phy_data_i;
          err_d         = err_n;
          if (lane_q == LaneW'(WordsPerBeat - 1)) begin
            data_d  = asm_d;
            resp_d  = err_n ? RESP_SLVERR : RESP_OKAY;
            last_d  = (beats_q == 8'd0);
            state_d = SEND;
          end else begin
            lane_d = lane_q + LaneW'(1);
          end
        end
      end
      SEND: begin
        r_valid_o   = 1'b1;
        phy_ready_o = r_ready_i && (beats_q != 8'd0);
        if (r_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            beats_d = beats_q - 8'd1;
            lane_d  = '0;
            asm_d   = '0;
            err_d   = 1'b0;
            state_d = PACK;
            // Zero-bubble: first word of the next beat lands now
            if (phy_valid_i) begin
              asm_d[0] = phy_data_i;
              lane_d   = LaneW'(1);
              err_d    = phy_err_i;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      beats_q <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= RESP_OKAY;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      beats_q <= beats_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      last_q  <= last_d;
    end
  end

  assign r_data_o = data_q;
  assign r_id_o   = id_q;
  assign r_resp_o = resp_q;
  assign r_last_o = last_q;

endmodule

// File: tb/tb_hyper_rx_upsizer.sv
// Directed bench for hyper_rx_upsizer at 64-bit R width.
module tb_hyper_rx_upsizer;

  localparam int DW = 64;
  localparam int IW = 6;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_offset;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic          phy_valid;
  logic          phy_ready;
  logic [15:0]   phy_data;
  logic          phy_err;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic [1:0]    r_resp;
  logic          r_last;

  hyper_rx_upsizer #(
    .AxiDataWidth(DW),
    .AxiIdWidth  (IW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_offset_i(cmd_offset),
    .cmd_len_i   (cmd_len),
    .cmd_id_i    (cmd_id),
    .phy_valid_i (phy_valid),
    .phy_ready_o (phy_ready),
    .phy_data_i  (phy_data),
    .phy_err_i   (phy_err),
    .r_valid_o   (r_valid),
    .r_ready_i   (r_ready),
    .r_data_o    (r_data),
    .r_id_o      (r_id),
    .r_resp_o    (r_resp),
    .r_last_o    (r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [15:0] wq[$];
  logic [63:0] bd[16];
  logic [1:0]  br[16];
  logic        bl[16];
  logic [5:0]  bi[16];
  int          bc[16];
  int          first_rv_cyc;
  int          lat_word_cyc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int b,
                                           input int off);
    logic [63:0] e;
    int g;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      g = b * 4 + l - off;
      if (g >= 0 && g < wq.size()) e[16*l +: 16] = wq[g];
    end
    return e;
  endfunction

  task automatic run_burst(input int off, input int len,
                           input int id, input int errw,
                           input int stall);
    int nw, sent, beats, cyc, stall_left;
    logic [63:0] held;
    nw = (len + 1) * 4 - off;
    sent = 0; beats = 0; cyc = 0; stall_left = stall;
    first_rv_cyc = -1; lat_word_cyc = -1; held = '0;
    chk("cmd_ready_before", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_offset = off[1:0];
    cmd_len = len[7:0];
    cmd_id = id[5:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (beats <= len && cyc < 2000) begin
      phy_valid = (sent < nw);
      phy_data = (sent < nw) ? wq[sent] : 16'h0;
      phy_err = (sent == errw);
      r_ready = !(r_valid && stall_left > 0);
      #1;
      if (r_valid && beats == 0 && first_rv_cyc < 0)
        first_rv_cyc = cyc;
      if (!r_ready) begin
        chk("stall_phy_ready", {63'd0, phy_ready}, 64'd0);
        if (stall_left == stall) held = r_data;
        else chk("stall_data_stable", r_data, held);
        stall_left--;
      end
      if (phy_valid && phy_ready) begin
        if (sent == 3 - off) lat_word_cyc = cyc;
        sent++;
      end
      if (r_valid && r_ready) begin
        bd[beats] = r_data;
        br[beats] = r_resp;
        bl[beats] = r_last;
        bi[beats] = r_id;
        bc[beats] = cyc;
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("beats_delivered", 64'(beats), 64'(len + 1));
    chk("words_used", 64'(sent), 64'(nw));
    phy_valid = 1'b1;
    phy_err = 1'b0;
    r_ready = 1'b1;
    #1;
    chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("idle_phy_ready", {63'd0, phy_ready}, 64'd0);
    chk("idle_r_valid", {63'd0, r_valid}, 64'd0);
    phy_valid = 1'b0;
    chk("beat0_latency", 64'(first_rv_cyc - lat_word_cyc),
        64'd1);
    for (int b = 0; b <= len && b < beats; b++) begin
      chk("beat_data", bd[b], exp_beat(b, off));
      chk("beat_id", 64'(bi[b]), 64'(id));
      chk("beat_resp", 64'(br[b]),
          ((errw >= 0) && ((errw + off) / 4 == b))
            ? 64'd2 : 64'd0);
      chk("beat_last", {63'd0, bl[b]},
          (b == len) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_phy_ready", {63'd0, phy_ready}, 64'd0);
    chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    chk("rst_r_id", 64'(r_id), 64'd0);
    chk("rst_r_resp", 64'(r_resp), 64'd0);
    chk("rst_r_last", {63'd0, r_last}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_offset = '0;
    cmd_len = '0; cmd_id = '0;
    phy_valid = 1'b0; phy_data = '0; phy_err = 1'b0;
    r_ready = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_burst(0, 0, 5, -1, 0);
    chk("t1_data", bd[0], 64'h4444_3333_2222_1111);

    wq = '{16'hAAAA, 16'hBBBB, 16'hCCCC,
           16'hDDDD, 16'hEEEE, 16'hFFFF};
    run_burst(2, 1, 9, -1, 0);
    chk("t2_beat0", bd[0], 64'hBBBB_AAAA_0000_0000);
    chk("t2_beat1", bd[1], 64'hFFFF_EEEE_DDDD_CCCC);

    wq.delete();
    for (int k = 0; k < 16; k++) wq.push_back(16'h3000 + 16'(k));
    run_burst(0, 3, 17, -1, 10);

    wq.delete();
    for (int k = 0; k < 12; k++) wq.push_back(16'h4000 + 16'(k));
    run_burst(0, 2, 33, 5, 0);

    wq.delete();
    for (int k = 0; k < 32; k++) wq.push_back(16'h5000 + 16'(k));
    run_burst(0, 7, 63, -1, 0);
    for (int b = 1; b < 8; b++)
      chk("t5_beat_spacing", 64'(bc[b] - bc[b-1]), 64'd4);

    wq = '{16'h6001, 16'h6002, 16'h6003, 16'h6004};
    cmd_valid = 1'b1; cmd_offset = 2'd0;
    cmd_len = 8'd1; cmd_id = 6'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    phy_valid = 1'b1; phy_data = 16'h6001;
    @(posedge clk); #1;
    phy_data = 16'h6002;
    @(posedge clk); #1;
    phy_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wq = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
    run_burst(0, 0, 3, -1, 0);
    chk("t6_data", bd[0], 64'h7004_7003_7002_7001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_rx_upsizer.md
Name: hyper_rx_upsizer

Overview:
- Read-data packer between the HyperBus PHY receive path and the AXI R channel of the hyperbus controller.
- Takes 16-bit DDR read words from the PHY and assembles them into AxiDataWidth-wide R beats.
- Applies the start-word offset of the burst, the beat count, the transaction ID and error flags.
- One command describes one AXI read burst; the block handles one burst at a time.

Parameters:
- AxiDataWidth, 64, R data width; power of two, 32..1024.
- AxiIdWidth, 6, R ID width.
- WordsPerBeat, AxiDataWidth/16, derived localparam; not user-overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  burst command ready
- cmd_offset_i  in  $clog2(WordsPerBeat)  first 16-bit lane used in beat 0
- cmd_len_i  in  8  AXI len (beats-1)
- cmd_id_i  in  AxiIdWidth  AXI ID returned on R
- phy_valid_i  in  1  PHY read word valid
- phy_ready_o  out  1  PHY read word ready
- phy_data_i  in  16  read word; [7:0] = lower-address byte
- phy_err_i  in  1  error flag qualified by phy_valid_i
- r_valid_o  out  1  R beat valid
- r_ready_i  in  1  R beat ready
- r_data_o  out  AxiDataWidth  R data
- r_id_o  out  AxiIdWidth  R ID
- r_resp_o  out  2  OKAY (2'b00) or SLVERR (2'b10)
- r_last_o  out  1  final beat of burst

Behaviour:
- Reset values:
  - cmd_ready_o = 1 (IDLE).
  - All other outputs = 0.
  - Assembly register, output register and counters = 0.
- FSM states: IDLE, PACK, SEND.
- IDLE:
  - cmd_ready_o = 1, phy_ready_o = 0.
  - On cmd handshake: latch id, beats_left = len, lane = offset, clear assembly register and error flag; go to PACK.
- PACK:
  - phy_ready_o = 1.
  - Each PHY handshake writes phy_data_i into lane `lane` (bits 16*lane+:16) and ORs phy_err_i into the beat error flag.
  - When lane == WordsPerBeat-1 at the handshake:
    - Copy assembly register to the output register.
    - resp = SLVERR if the error flag is set (including the current word), else OKAY.
    - r_last = (beats_left == 0).
    - Go to SEND.
  - Otherwise lane increments.
- SEND:
  - r_valid_o = 1; r_data/id/resp/last held stable until r_ready_i.
  - On r handshake with r_last_o = 1: go to IDLE.
  - On r handshake with beats_left > 0: decrement beats_left, lane = 0, clear error flag; go to PACK.
  - Bypass: in SEND, phy_ready_o = r_ready_i && (beats_left != 0). A word accepted in that cycle is written to lane 0 of the fresh assembly register and lane becomes 1 (error flag = that word's phy_err_i). This gives zero-bubble streaming.
- Latency: r_valid_o rises the cycle after the handshake of the beat's final PHY word.
- Throughput: one beat per WordsPerBeat cycles with no backpressure.
- Lanes below cmd_offset_i in beat 0 read as 0. Beats after beat 0 always start at lane 0.
- Total PHY words consumed per burst = (len+1)*WordsPerBeat - offset. The PHY supplies exactly this many; extra words are not accepted (phy_ready_o = 0 in IDLE).
- Simultaneous events:
  - cmd_valid_i is ignored outside IDLE.
  - Asserting phy_valid_i in IDLE is legal and is not consumed.
- Errors never shorten a burst; all beats are delivered.
- Reset asserted mid-burst: immediate return to IDLE with reset values; partial data is discarded.

Decomposition:
- Shared hyperbus package holds:
  - the 16-bit PHY word typedef;
  - a WordsPerBeat helper function.
- Response codes come from axi_pkg (RESP_OKAY, RESP_SLVERR).
- No sub-module; a single always_ff for the FSM and registers plus combinational ready/valid logic.

Test Plan:
- DW=64, len=0, offset=0, id=5, words 1111,2222,3333,4444, r_ready=1 -> one beat: data 0x4444_3333_2222_1111, id 5, resp 00, last 1; r_valid one cycle after 4444 accepted.
- offset=2, len=1, words A..F -> beat0 0xBBBB_AAAA_0000_0000, last 0; beat1 0xFFFF_EEEE_DDDD_CCCC, last 1; exactly 6 words consumed.
- len=3, r_ready low for 10 cycles at beat0 -> phy_ready_o 0 throughout, r_data stable, no word lost; all 4 beats correct afterwards.
- len=2, phy_err_i on the 2nd word of beat1 -> resp 00/10/00 for beats 0/1/2, and 3 beats still delivered.
- len=7, phy_valid and r_ready held 1 -> 8 beats, one every 4 cycles, no bubbles; last only on beat 7; cmd_ready_o returns 1 after the final handshake.
- rst_ni pulsed low after 2 words of a len=1 burst -> all outputs 0 and cmd_ready_o 1; a new len=0 burst then completes correctly.
